// File: rtl/serial_adder.sv
// ============================================================================
// Module      : serial_adder
// Description : Multi-cycle WIDTH-bit adder that processes DIGIT bits per
//               clock through a full-adder chain. Uses a start/busy/done
//               handshake. Defining SERIAL_ADDER_OVF_EN adds a signed
//               overflow output (ovf).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_adder #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             Cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] y,
    output logic             Cout
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int N  = (DIGIT > 0) ? (WIDTH / DIGIT) : 1;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    generate
        if ((WIDTH < 1) || (DIGIT < 1) || ((WIDTH % DIGIT) != 0)) begin : g_bad_params
            $error("serial_adder: DIGIT must be >= 1 and divide WIDTH exactly");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, b_q, y_q;
    logic             carry_q, cout_q;
    logic [CW-1:0]    cnt_q;
    logic             w_load, w_step, w_last;
    logic [DIGIT-1:0] w_sum;
    logic [DIGIT:0]   w_chain_c;
    logic [WIDTH-1:0] w_res_next;

    // Ripple chain over the low digit of the operand shift registers
    assign w_chain_c[0] = carry_q;
    generate
        for (genvar i = 0; i < DIGIT; i++) begin : g_fa
            assign w_sum[i]       = a_q[i] ^ b_q[i] ^ w_chain_c[i];
            assign w_chain_c[i+1] = (a_q[i] & b_q[i]) | (w_chain_c[i] & (a_q[i] ^ b_q[i]));
        end
    endgenerate

    // Partial result holds only the digits already produced; the newest
    // digit enters at the top so the final step yields the whole sum.
    generate
        if (N > 1) begin : g_res_multi
            logic [WIDTH-DIGIT-1:0] res_q;
            assign w_res_next = {w_sum, res_q};
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    res_q <= '0;
                end else if (w_step) begin
                    res_q <= w_res_next[WIDTH-1:DIGIT];
                end
            end
        end else begin : g_res_single
            assign w_res_next = w_sum;
        end
    endgenerate

    assign w_last = (cnt_q == CW'(N - 1));

    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        done    = 1'b0;
        w_load  = 1'b0;
        w_step  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    w_load  = 1'b1;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                busy   = 1'b1;
                w_step = 1'b1;
                if (w_last) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                done = 1'b1;
                if (start) begin
                    w_load  = 1'b1;
                    state_d = S_RUN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            y_q     <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (w_load) begin
                a_q     <= a;
                b_q     <= b;
                carry_q <= Cin;
                cnt_q   <= '0;
            end else if (w_step) begin
                a_q     <= a_q >> DIGIT;
                b_q     <= b_q >> DIGIT;
                carry_q <= w_chain_c[DIGIT];
                cnt_q   <= cnt_q + 1'b1;
                if (w_last) begin
                    y_q    <= w_res_next;
                    cout_q <= w_chain_c[DIGIT];
                end
            end
        end
    end

    assign y    = y_q;
    assign Cout = cout_q;

`ifdef SERIAL_ADDER_OVF_EN
    logic ovf_q;

    // Carry into the MSB is the chain tap just below the final digit's top bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (w_step && w_last) begin
            ovf_q <= w_chain_c[DIGIT-1] ^ w_chain_c[DIGIT];
        end
    end

    assign ovf = ovf_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_serial_adder.sv
// ============================================================================
// Module      : tb_serial_adder
// Description : Self-checking bench for serial_adder; four configurations
//               (8,1) (8,2) (16,4) (8,8) share one stimulus stream.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serial_adder;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] a     = '0;
    logic [15:0] b     = '0;
    logic        cin   = 1'b0;

    always #5 clk = ~clk;

    logic        busy_v [4];
    logic        done_v [4];
    logic        cout_v [4];
    logic        ovf_v  [4];
    logic [31:0] y_v    [4];
    logic [7:0]  y0, y1, y3;
    logic [15:0] y2;

    assign y_v[0] = {24'd0, y0};
    assign y_v[1] = {24'd0, y1};
    assign y_v[2] = {16'd0, y2};
    assign y_v[3] = {24'd0, y3};

    serial_adder #(.WIDTH(8), .DIGIT(1)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a[7:0]), .b(b[7:0]), .Cin(cin),
        .busy(busy_v[0]), .done(done_v[0]), .y(y0), .Cout(cout_v[0])
`ifdef SERIAL_ADDER_OVF_EN
        , .ovf(ovf_v[0])
`endif
    );
    serial_adder #(.WIDTH(8), .DIGIT(2)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a[7:0]), .b(b[7:0]), .Cin(cin),
        .busy(busy_v[1]), .done(done_v[1]), .y(y1), .Cout(cout_v[1])
`ifdef SERIAL_ADDER_OVF_EN
        , .ovf(ovf_v[1])
`endif
    );
    serial_adder #(.WIDTH(16), .DIGIT(4)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .Cin(cin),
        .busy(busy_v[2]), .done(done_v[2]), .y(y2), .Cout(cout_v[2])
`ifdef SERIAL_ADDER_OVF_EN
        , .ovf(ovf_v[2])
`endif
    );
    serial_adder #(.WIDTH(8), .DIGIT(8)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a[7:0]), .b(b[7:0]), .Cin(cin),
        .busy(busy_v[3]), .done(done_v[3]), .y(y3), .Cout(cout_v[3])
`ifdef SERIAL_ADDER_OVF_EN
        , .ovf(ovf_v[3])
`endif
    );

`ifndef SERIAL_ADDER_OVF_EN
    initial for (int i = 0; i < 4; i++) ovf_v[i] = 1'b0;
`endif

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // Transaction-level model: an accepted operation completes N edges later
    // with the arithmetic sum; outputs otherwise hold.
    int          c_w   [4] = '{8, 8, 16, 8};
    int          c_n   [4] = '{8, 4, 4, 1};
    int          m_rem [4] = '{0, 0, 0, 0};
    logic        m_done[4] = '{0, 0, 0, 0};
    logic [31:0] m_y   [4] = '{0, 0, 0, 0};
    logic        m_c   [4] = '{0, 0, 0, 0};
    logic        m_o   [4] = '{0, 0, 0, 0};
    logic [31:0] p_y   [4];
    logic        p_c   [4];
    logic        p_o   [4];

    task automatic model_sum(input int w, input logic [15:0] ia, input logic [15:0] ib,
                             input logic ic, output logic [31:0] s, output logic co,
                             output logic ov);
        logic [31:0] mask, full;
        mask = (32'd1 << w) - 32'd1;
        full = ({16'd0, ia} & mask) + ({16'd0, ib} & mask) + {31'd0, ic};
        s    = full & mask;
        co   = full[w];
        ov   = (ia[w-1] == ib[w-1]) && (s[w-1] != ia[w-1]);
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                for (int i = 0; i < 4; i++) begin
                    m_rem[i] = 0; m_done[i] = 0; m_y[i] = '0; m_c[i] = 0; m_o[i] = 0;
                end
            end else begin
                for (int i = 0; i < 4; i++) begin
                    m_done[i] = 1'b0;
                    if (m_rem[i] > 0) begin
                        m_rem[i]--;
                        if (m_rem[i] == 0) begin
                            m_y[i] = p_y[i]; m_c[i] = p_c[i]; m_o[i] = p_o[i];
                            m_done[i] = 1'b1;
                        end
                    end else if (start) begin
                        model_sum(c_w[i], a, b, cin, p_y[i], p_c[i], p_o[i]);
                        m_rem[i] = c_n[i];
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            for (int i = 0; i < 4; i++) begin
                chk($sformatf("busy[%0d]", i), {31'd0, busy_v[i]}, {31'd0, m_rem[i] > 0});
                chk($sformatf("done[%0d]", i), {31'd0, done_v[i]}, {31'd0, m_done[i]});
                chk($sformatf("y[%0d]", i), y_v[i], m_y[i]);
                chk($sformatf("Cout[%0d]", i), {31'd0, cout_v[i]}, {31'd0, m_c[i]});
`ifdef SERIAL_ADDER_OVF_EN
                chk($sformatf("ovf[%0d]", i), {31'd0, ovf_v[i]}, {31'd0, m_o[i]});
`endif
            end
        end
    end

    function automatic logic all_idle();
        logic r = 1'b1;
        for (int i = 0; i < 4; i++) if (busy_v[i] || done_v[i]) r = 1'b0;
        return r;
    endfunction

    // Called right after a negedge; lat counts negedges from the start edge,
    // so a done N edges after acceptance is seen at lat = N+1.
    task automatic run_op(input logic [15:0] ia, input logic [15:0] ib, input logic ic,
                          output int lat0, output int lat2, output int nbusy0);
        a = ia; b = ib; cin = ic; start = 1'b1;
        lat0 = -1; lat2 = -1; nbusy0 = 0;
        for (int t = 1; t <= 30; t++) begin
            @(negedge clk);
            if (t == 1) start = 1'b0;
            if (busy_v[0]) nbusy0++;
            if (done_v[0] && lat0 < 0) lat0 = t;
            if (done_v[2] && lat2 < 0) lat2 = t;
            if (lat0 > 0 && t > lat0 && all_idle()) break;
        end
        if (lat0 < 0) chk("op_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_done0(output int t_seen);
        t_seen = -1;
        for (int t = 1; t <= 30; t++) begin
            @(negedge clk);
            if (done_v[0]) begin t_seen = t; break; end
        end
        if (t_seen < 0) chk("done_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int l0, l2, nb, g;
        repeat (2) @(negedge clk);
        chk("rst_busy", {31'd0, busy_v[0]}, 32'd0);
        chk("rst_y", y_v[0], 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_op(16'h005A, 16'h003C, 1'b0, l0, l2, nb);
        chk("lat_8_1", l0, 32'd9);
        chk("busy_cycles", nb, 32'd8);
        chk("y_5A_3C", y_v[0], 32'h96);
        chk("c_5A_3C", {31'd0, cout_v[0]}, 32'd0);

        run_op(16'h00FF, 16'h0001, 1'b0, l0, l2, nb);
        chk("y_FF_01", y_v[0], 32'h00);
        chk("c_FF_01", {31'd0, cout_v[0]}, 32'd1);
`ifdef SERIAL_ADDER_OVF_EN
        chk("o_FF_01", {31'd0, ovf_v[0]}, 32'd0);
`endif
        run_op(16'h007F, 16'h0001, 1'b0, l0, l2, nb);
        chk("y_7F_01", y_v[0], 32'h80);
        chk("c_7F_01", {31'd0, cout_v[0]}, 32'd0);
`ifdef SERIAL_ADDER_OVF_EN
        chk("o_7F_01", {31'd0, ovf_v[0]}, 32'd1);
`endif
        run_op(16'h00FF, 16'h00FF, 1'b1, l0, l2, nb);
        chk("y_FF_FF_1", y_v[0], 32'hFF);
        chk("c_FF_FF_1", {31'd0, cout_v[0]}, 32'd1);
        chk("y88_FF_FF_1", y_v[3], 32'hFF);

        run_op(16'h1234, 16'hEDCC, 1'b0, l0, l2, nb);
        chk("lat_16_4", l2, 32'd5);
        chk("y16_1234", y_v[2], 32'h0000);
        chk("c16_1234", {31'd0, cout_v[2]}, 32'd1);

        // start held high; operands change mid-run and must be ignored
        a = 16'h0011; b = 16'h0022; start = 1'b1;
        @(negedge clk);
        a = 16'h0040; b = 16'h0001;
        wait_done0(g);
        chk("held_lat", g + 1, 32'd9);
        chk("held_y1", y_v[0], 32'h33);
        chk("held_busy_in_done", {31'd0, busy_v[0]}, 32'd0);
        g = 0;
        for (int t = 1; t <= 30; t++) begin
            @(negedge clk);
            if (t == 4) chk("held_y_hold", y_v[0], 32'h33);
            if (done_v[0]) begin g = t; break; end
        end
        start = 1'b0;
        chk("held_gap", g, 32'd9);
        chk("held_y2", y_v[0], 32'h41);
        for (int t = 0; t < 30 && !all_idle(); t++) @(negedge clk);

        // asynchronous reset in cycle 4 of 8
        a = 16'h0010; b = 16'h0020; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", {31'd0, busy_v[0]}, 32'd0);
        chk("arst_done", {31'd0, done_v[0]}, 32'd0);
        chk("arst_y", y_v[0], 32'd0);
        chk("arst_c", {31'd0, cout_v[0]}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_op(16'h0001, 16'h0002, 1'b0, l0, l2, nb);
        chk("post_rst_y", y_v[0], 32'h03);

        for (int k = 0; k < 1000; k++) begin
            run_op(16'($urandom), 16'($urandom), 1'($urandom), l0, l2, nb);
        end

        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
